hworld_obi_seq: RTL



---
 rtl/hworld_seq_pkg.sv | 47 ++++
 rtl/obi_pkg.sv | 20 ++
 rtl/hworld_obi_seq.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/hworld_seq_pkg.sv
// Register map and state encoding of the hworld OBI sequencer.
// The offsets are the single source of truth for the hworld register map.
package hworld_seq_pkg;

   localparam logic [31:0] HWORLD_A_OFFS    = 32'h0000_0000;
   localparam logic [31:0] HWORLD_B_OFFS    = 32'h0000_0004;
   localparam logic [31:0] HWORLD_SUM_OFFS  = 32'h0000_0008;
   localparam logic [31:0] HWORLD_COUT_OFFS = 32'h0000_000C;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_WR_A_REQ = 4'd1,
      ST_WR_A_RSP = 4'd2,
      ST_WR_B_REQ = 4'd3,
      ST_WR_B_RSP = 4'd4,
      ST_RD_S_REQ = 4'd5,
      ST_RD_S_RSP = 4'd6,
      ST_RD_C_REQ = 4'd7,
      ST_RD_C_RSP = 4'd8,
      ST_DONE     = 4'd9
   } hworld_seq_state_e;

   // True in the states that drive req on the bus.
   function automatic logic is_req_state(input hworld_seq_state_e s);
      return (s == ST_WR_A_REQ) || (s == ST_WR_B_REQ) ||
             (s == ST_RD_S_REQ) || (s == ST_RD_C_REQ);
   endfunction

   // True in every state that is spent on the bus (request or response phase).
   function automatic logic is_bus_state(input hworld_seq_state_e s);
      return (s != ST_IDLE) && (s != ST_DONE);
   endfunction

   // Register offset addressed by a given state.
   function automatic logic [31:0] state_offs(input hworld_seq_state_e s);
      logic [31:0] offs;
      case (s)
         ST_WR_A_REQ, ST_WR_A_RSP: offs = HWORLD_A_OFFS;
         ST_WR_B_REQ, ST_WR_B_RSP: offs = HWORLD_B_OFFS;
         ST_RD_S_REQ, ST_RD_S_RSP: offs = HWORLD_SUM_OFFS;
         ST_RD_C_REQ, ST_RD_C_RSP: offs = HWORLD_COUT_OFFS;
         default:                  offs = 32'h0000_0000;
      endcase
      return offs;
   endfunction

endpackage

// File: rtl/obi_pkg.sv
// OBI bus types shared by masters and slaves.
//   obi_req_t : req, addr, we, be, wdata (master -> slave)
//   obi_rsp_t : gnt, rvalid, rdata       (slave -> master)
package obi_pkg;

   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_rsp_t;

endpackage

// File: rtl/hworld_obi_seq.sv
// OBI master sequencer for the hworld adder peripheral.
// On an accepted start it writes A and B, reads SUM and COUT, then pulses done.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   start_i, a_i, b_i  operation request and operands (sampled in IDLE only)
//   busy_o, done_o     operation in progress / one-cycle completion pulse
//   sum_o, cout_o      results of the last operation
//   cycles_o           saturating count of bus cycles of the last operation
//   obi_req_o/rsp_i    OBI master port
// All outputs are registered: the bus request for the next cycle is derived
// from the next state, so req/addr/we/wdata change only on clock edges.
module hworld_obi_seq
   import obi_pkg::*;
   import hworld_seq_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          CYC_W     = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [31:0]      a_i,
   input  logic [31:0]      b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [31:0]      sum_o,
   output logic             cout_o,
   output logic [CYC_W-1:0] cycles_o,
   output obi_req_t         obi_req_o,
   input  obi_rsp_t         obi_rsp_i
);

   localparam logic [CYC_W-1:0] CYC_MAX = {CYC_W{1'b1}};
   localparam logic [CYC_W-1:0] CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};

   hworld_seq_state_e state_r, state_nxt;
   obi_req_t          bus_r, bus_nxt;
   logic [31:0]       a_r, b_r, sum_shadow_r;
   logic [CYC_W-1:0]  cnt_r, cnt_inc;
   logic              busy_r, done_r, cout_r;
   logic [31:0]       sum_r;
   logic [CYC_W-1:0]  cycles_r;
   logic              accept;

   assign accept  = (state_r == ST_IDLE) && start_i;
   assign cnt_inc = (cnt_r == CYC_MAX) ? cnt_r : (cnt_r + CYC_ONE);

   // Next-state logic; rvalid is only looked at in response states, so an
   // rvalid coinciding with gnt is never taken as the response.
   always_comb begin
      state_nxt = state_r;
      case (state_r)
         ST_IDLE:     state_nxt = start_i           ? ST_WR_A_REQ : ST_IDLE;
         ST_WR_A_REQ: state_nxt = obi_rsp_i.gnt     ? ST_WR_A_RSP : ST_WR_A_REQ;
         ST_WR_A_RSP: state_nxt = obi_rsp_i.rvalid  ? ST_WR_B_REQ : ST_WR_A_RSP;
         ST_WR_B_REQ: state_nxt = obi_rsp_i.gnt     ? ST_WR_B_RSP : ST_WR_B_REQ;
         ST_WR_B_RSP: state_nxt = obi_rsp_i.rvalid  ? ST_RD_S_REQ : ST_WR_B_RSP;
         ST_RD_S_REQ: state_nxt = obi_rsp_i.gnt     ? ST_RD_S_RSP : ST_RD_S_REQ;
         ST_RD_S_RSP: state_nxt = obi_rsp_i.rvalid  ? ST_RD_C_REQ : ST_RD_S_RSP;
         ST_RD_C_REQ: state_nxt = obi_rsp_i.gnt     ? ST_RD_C_RSP : ST_RD_C_REQ;
         ST_RD_C_RSP: state_nxt = obi_rsp_i.rvalid  ? ST_DONE     : ST_RD_C_RSP;
         ST_DONE:     state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   // Bus request for the next cycle; A comes straight from a_i on the
   // acceptance edge because a_r is loaded on that same edge.
   always_comb begin
      bus_nxt = '{req: 1'b0, addr: 32'h0000_0000, we: 1'b0, be: 4'h0, wdata: 32'h0000_0000};
      if (is_req_state(state_nxt)) begin
         bus_nxt.req  = 1'b1;
         bus_nxt.addr = BASE_ADDR + state_offs(state_nxt);
         bus_nxt.be   = 4'hF;
         case (state_nxt)
            ST_WR_A_REQ: begin
               bus_nxt.we    = 1'b1;
               bus_nxt.wdata = (state_r == ST_IDLE) ? a_i : a_r;
            end
            ST_WR_B_REQ: begin
               bus_nxt.we    = 1'b1;
               bus_nxt.wdata = b_r;
            end
            default: begin
               bus_nxt.we    = 1'b0;
               bus_nxt.wdata = 32'h0000_0000;
            end
         endcase
      end else begin
         bus_nxt.req = 1'b0;
      end
   end

   // State, operand latches, shadow SUM and saturating bus-cycle counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r      <= ST_IDLE;
         a_r          <= 32'h0000_0000;
         b_r          <= 32'h0000_0000;
         sum_shadow_r <= 32'h0000_0000;
         cnt_r        <= {CYC_W{1'b0}};
      end else begin
         state_r <= state_nxt;
         if (accept) begin
            a_r   <= a_i;
            b_r   <= b_i;
            cnt_r <= {CYC_W{1'b0}};
         end else if (is_bus_state(state_r)) begin
            cnt_r <= cnt_inc;
         end
         if ((state_r == ST_RD_S_RSP) && obi_rsp_i.rvalid) begin
            sum_shadow_r <= obi_rsp_i.rdata;
         end
      end
   end

   // Registered outputs; results are published on the edge entering DONE so
   // they are valid in the same cycle as done_o. COUT goes straight from the
   // bus into the output register on that edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bus_r    <= '{req: 1'b0, addr: 32'h0000_0000, we: 1'b0, be: 4'h0, wdata: 32'h0000_0000};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         sum_r    <= 32'h0000_0000;
         cout_r   <= 1'b0;
         cycles_r <= {CYC_W{1'b0}};
      end else begin
         bus_r  <= bus_nxt;
         busy_r <= is_bus_state(state_nxt);
         done_r <= (state_nxt == ST_DONE);
         if ((state_r == ST_RD_C_RSP) && obi_rsp_i.rvalid) begin
            sum_r    <= sum_shadow_r;
            cout_r   <= obi_rsp_i.rdata[0];
            cycles_r <= cnt_inc;
         end
      end
   end

   assign obi_req_o = bus_r;
   assign busy_o    = busy_r;
   assign done_o    = done_r;
   assign sum_o     = sum_r;
   assign cout_o    = cout_r;
   assign cycles_o  = cycles_r;

endmodule
